// File: rtl/conv_stride_sequencer.sv
// conv_stride_sequencer: control sequencer for a strided 2D convolution.
// Walks output windows, issues X/W taps and credit-throttles against fifo_out.
module conv_stride_sequencer #(
    parameter  int R          = 8,
    parameter  int C          = 8,
    parameter  int MAXK       = 5,
    parameter  int MAXS       = 3,
    parameter  int MAC_LAT    = 4,
    parameter  int FIFO_DEPTH = 16,
    localparam int K_BITS     = $clog2(MAXK + 1),
    localparam int S_BITS     = $clog2(MAXS + 1),
    localparam int XA         = $clog2(R * C),
    localparam int WA         = $clog2(MAXK * MAXK)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inputs_loaded,
    input  logic [K_BITS-1:0] K,
    input  logic [S_BITS-1:0] S,
    input  logic              fifo_pop,
    output logic [XA-1:0]     X_read_addr,
    output logic [WA-1:0]     W_read_addr,
    output logic              mac_input_valid,
    output logic              mac_init_acc,
    output logic              fifo_in_valid,
    output logic              compute_finished
);

    localparam int PW = $clog2(((R > C) ? R : C) + MAXS + MAXK + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, CREDIT, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [K_BITS-1:0] kq;
    logic [K_BITS-1:0] i;
    logic [K_BITS-1:0] j;
    logic [S_BITS-1:0] sq;
    logic [PW-1:0]     rb;
    logic [PW-1:0]     cb;
    logic [WA-1:0]     w_cnt;
    logic [CW-1:0]     credits;
    logic              issue_q;
    logic              init_q;
    logic              last_q;
    logic [MAC_LAT:0]  dl;

    logic          legal;
    logic          reserve;
    logic          can_issue;
    logic          last_j;
    logic          last_i;
    logic          tap_last;
    logic          row_last;
    logic          col_last;
    logic          win_last;
    logic [XA-1:0] x_cur;

    // Job legality, tap/window position flags and the current X address
    always_comb begin
        legal = (K != '0) && (32'(K) <= MAXK) && (32'(K) <= R)
              && (32'(K) <= C) && (S != '0) && (32'(S) <= MAXS);
        reserve   = (state == CREDIT) && (credits != '0);
        can_issue = reserve || (state == RUN);
        last_j    = (j == kq - K_BITS'(1));
        last_i    = (i == kq - K_BITS'(1));
        tap_last  = last_j && last_i;
        row_last  = (32'(rb) + 32'(sq) + 32'(kq)) > R;
        col_last  = (32'(cb) + 32'(sq) + 32'(kq)) > C;
        win_last  = row_last && col_last;
        x_cur     = XA'((32'(rb) + 32'(i)) * 32'(C) + 32'(cb) + 32'(j));
    end

    // Main FSM: job start, tap issue, window stepping, drain and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            kq               <= '0;
            sq               <= '0;
            i                <= '0;
            j                <= '0;
            rb               <= '0;
            cb               <= '0;
            w_cnt            <= '0;
            issue_q          <= 1'b0;
            init_q           <= 1'b0;
            last_q           <= 1'b0;
            X_read_addr      <= '0;
            W_read_addr      <= '0;
            compute_finished <= 1'b0;
        end else begin
            issue_q          <= 1'b0;
            init_q           <= 1'b0;
            last_q           <= 1'b0;
            compute_finished <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (inputs_loaded && !compute_finished) begin
                        kq    <= K;
                        sq    <= S;
                        i     <= '0;
                        j     <= '0;
                        rb    <= '0;
                        cb    <= '0;
                        w_cnt <= '0;
                        if (legal) begin
                            state <= CREDIT;
                        end else begin
                            state            <= DONE;
                            compute_finished <= 1'b1;
                        end
                    end
                end
                CREDIT, RUN: begin
                    if (can_issue) begin
                        X_read_addr <= x_cur;
                        W_read_addr <= w_cnt;
                        issue_q     <= 1'b1;
                        init_q      <= (i == '0) && (j == '0);
                        last_q      <= tap_last;
                        if (!last_j) begin
                            j     <= j + K_BITS'(1);
                            w_cnt <= w_cnt + WA'(1);
                            state <= RUN;
                        end else if (!last_i) begin
                            j     <= '0;
                            i     <= i + K_BITS'(1);
                            w_cnt <= w_cnt + WA'(1);
                            state <= RUN;
                        end else begin
                            j     <= '0;
                            i     <= '0;
                            w_cnt <= '0;
                            if (win_last) begin
                                state <= DRAIN;
                            end else begin
                                state <= CREDIT;
                                if (col_last) begin
                                    cb <= '0;
                                    rb <= rb + PW'(sq);
                                end else begin
                                    cb <= cb + PW'(sq);
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!last_q && (dl[MAC_LAT-1:0] == '0)) begin
                        state            <= DONE;
                        compute_finished <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Align strobes with memory read data and delay the last-tap flag to mac out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_input_valid <= 1'b0;
            mac_init_acc    <= 1'b0;
            dl              <= '0;
        end else begin
            mac_input_valid <= issue_q;
            mac_init_acc    <= init_q;
            dl              <= {dl[MAC_LAT-1:0], last_q};
        end
    end

    assign fifo_in_valid = dl[MAC_LAT];

    // Output FIFO credits: reserve per window, return per pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits <= CW'(FIFO_DEPTH);
        end else begin
            assert (!(fifo_pop && !reserve && credits == CW'(FIFO_DEPTH)))
                else $error("credit counter overflow");
            assert (32'(credits) <= FIFO_DEPTH)
                else $error("credit counter out of range");
            if (reserve && !fifo_pop) begin
                credits <= credits - CW'(1);
            end else if (!reserve && fifo_pop) begin
                credits <= credits + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_stride_sequencer.sv
// tb_conv_stride_sequencer: directed bench for conv_stride_sequencer.
// Models fifo_out occupancy and logs taps, pushes and done pulses.
module tb_conv_stride_sequencer;

    localparam int MAC_LAT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       inputs_loaded = 1'b0;
    logic [2:0] K = '0;
    logic [1:0] S = '0;
    logic       fifo_pop = 1'b0;
    logic [5:0] X_read_addr;
    logic [4:0] W_read_addr;
    logic       mac_input_valid;
    logic       mac_init_acc;
    logic       fifo_in_valid;
    logic       compute_finished;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int occ = 0;
    int start_cyc = 0;
    int prev_x = 0;
    int prev_w = 0;
    bit auto_pop = 1'b0;
    bit manual_pop = 1'b0;
    logic pop_now;

    int xlog[$];
    int wlog[$];
    int ilog[$];
    int vcyc[$];
    int fcyc[$];
    int dcyc[$];

    conv_stride_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .inputs_loaded    (inputs_loaded),
        .K                (K),
        .S                (S),
        .fifo_pop         (fifo_pop),
        .X_read_addr      (X_read_addr),
        .W_read_addr      (W_read_addr),
        .mac_input_valid  (mac_input_valid),
        .mac_init_acc     (mac_init_acc),
        .fifo_in_valid    (fifo_in_valid),
        .compute_finished (compute_finished)
    );

    always #5 clk = ~clk;

    assign pop_now = (auto_pop || manual_pop) && (occ > 0);

    // Mid-cycle monitor: tap log, push/done log and fifo_out occupancy model
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mac_input_valid) begin
            xlog.push_back(prev_x);
            wlog.push_back(prev_w);
            ilog.push_back(int'(mac_init_acc));
            vcyc.push_back(cyc + 1);
        end
        if (fifo_in_valid) fcyc.push_back(cyc + 1);
        if (compute_finished) dcyc.push_back(cyc + 1);
        prev_x <= int'(X_read_addr);
        prev_w <= int'(W_read_addr);
        if (!reset) begin
            occ      <= 0;
            fifo_pop <= 1'b0;
        end else begin
            fifo_pop <= pop_now;
            occ      <= occ + int'(fifo_in_valid) - int'(pop_now);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int count_init();
        int n = 0;
        foreach (ilog[k]) n += ilog[k];
        return n;
    endfunction

    task automatic start_job(input logic [2:0] k, input logic [1:0] s);
        xlog.delete();
        wlog.delete();
        ilog.delete();
        vcyc.delete();
        fcyc.delete();
        dcyc.delete();
        K = k;
        S = s;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        inputs_loaded = 1'b1;
        @(posedge clk);
        #1;
        inputs_loaded = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (dcyc.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(tag, dcyc.size(), 1);
    endtask

    int exp_t1[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int exp_t4[9] = '{0, 3, 6, 24, 27, 30, 48, 51, 54};
    int bad;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({X_read_addr, W_read_addr, mac_input_valid,
              mac_init_acc, fifo_in_valid, compute_finished}), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // 1: K=3 S=1, popping freely
        auto_pop = 1'b1;
        start_job(3'd3, 2'd1);
        wait_done("t1_done", 1000);
        check("t1_pulses", fcyc.size(), 36);
        check("t1_taps", xlog.size(), 324);
        check("t1_windows", count_init(), 36);
        for (int n = 0; n < 9; n++) begin
            check($sformatf("t1_x%0d", n), xlog[n], exp_t1[n]);
            check($sformatf("t1_w%0d", n), wlog[n], n);
        end
        check("t1_init0", ilog[0], 1);
        check("t1_init1", ilog[1], 0);
        check("t1_first_lat", fcyc[0] - vcyc[8], MAC_LAT);
        check("t1_gap0", fcyc[1] - fcyc[0], 9);
        bad = 0;
        for (int n = 1; n < fcyc.size(); n++)
            if (fcyc[n] - fcyc[n-1] != 9) bad++;
        check("t1_gaps_bad", bad, 0);
        check("t1_done_after_push", dcyc[0] - fcyc[35], 1);

        // 2: K=3 S=2
        start_job(3'd3, 2'd2);
        wait_done("t2_done", 1000);
        check("t2_pulses", fcyc.size(), 9);
        check("t2_win01", xlog[9], 2);
        check("t2_win10", xlog[27], 16);
        check("t2_last_x", xlog[80], 54);
        check("t2_last_w", wlog[80], 8);
        check("t2_done_lat", dcyc[0] - (vcyc[80] - 1), MAC_LAT + 2);

        // 3: K=2 S=1 with no pops, then one pop, then free
        auto_pop = 1'b0;
        start_job(3'd2, 2'd1);
        repeat (120) @(posedge clk);
        #1;
        check("t3_stall_windows", count_init(), 16);
        check("t3_stall_taps", xlog.size(), 64);
        check("t3_stall_pulses", fcyc.size(), 16);
        check("t3_no_done", dcyc.size(), 0);
        manual_pop = 1'b1;
        @(posedge clk);
        #1;
        manual_pop = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t3_one_more", count_init(), 17);
        check("t3_one_more_pulse", fcyc.size(), 17);
        auto_pop = 1'b1;
        wait_done("t3_done", 2000);
        check("t3_total", fcyc.size(), 49);

        // 4: K=1 S=3
        start_job(3'd1, 2'd3);
        wait_done("t4_done", 500);
        check("t4_pulses", fcyc.size(), 9);
        check("t4_taps", xlog.size(), 9);
        check("t4_init_all", count_init(), 9);
        for (int n = 0; n < 9; n++)
            check($sformatf("t4_x%0d", n), xlog[n], exp_t4[n]);

        // 5: illegal jobs
        start_job(3'd6, 2'd1);
        wait_done("t5a_done", 50);
        check("t5a_latency", dcyc[0] - start_cyc, 2);
        check("t5a_valids", xlog.size() + fcyc.size(), 0);
        start_job(3'd3, 2'd0);
        wait_done("t5b_done", 50);
        check("t5b_latency", dcyc[0] - start_cyc, 2);
        check("t5b_valids", xlog.size() + fcyc.size(), 0);

        // 6: reset mid-RUN, then a clean rerun
        start_job(3'd3, 2'd1);
        repeat (20) @(posedge clk);
        #1;
        check("t6_running", 32'(xlog.size() > 0), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_zero", 32'({X_read_addr, W_read_addr, mac_input_valid,
              mac_init_acc, fifo_in_valid, compute_finished}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start_job(3'd3, 2'd1);
        wait_done("t6_done", 1000);
        check("t6_pulses", fcyc.size(), 36);
        check("t6_x0", xlog[0], 0);
        check("t6_w0", wlog[0], 0);
        check("t6_init0", ilog[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
